// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder and its helpers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dm_pkg;
   localparam int DM_ADDR_W   = 32;
   localparam int DM_DATA_W   = 32;
   localparam int DM_BE_W     = DM_DATA_W / 8;
   localparam int LATENCY_MAX = 15;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dm_state_t;
endpackage

// File: rtl/dm_responder_if.sv
// CPU <-> data-memory request/response bundle.
// Latency: n/a (wires only).
// Backpressure: requester holds req_* stable while req_valid & ~resp_ack.
// master: CPU side (drives req_*); slave: memory side (drives resp_*, busy).
interface dm_responder_if;
   import dm_pkg::*;

   logic                 req_valid;
   logic                 req_we;
   logic [DM_ADDR_W-1:0] req_addr;
   logic [DM_DATA_W-1:0] req_wdata;
   logic [DM_BE_W-1:0]   req_be;
   logic [DM_ADDR_W-1:0] req_pc;
   logic                 resp_ack;
   logic [DM_DATA_W-1:0] resp_rdata;
   logic                 resp_err;
   logic                 busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be, req_pc,
      input  resp_ack, resp_rdata, resp_err, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be, req_pc,
      output resp_ack, resp_rdata, resp_err, busy
   );
endinterface

// File: rtl/dm_be_merge.sv
// Byte-enable merge: lanes with be[i]=1 take wdata, others keep old_word.
// Latency: combinational.
// Backpressure: none.
// Ports: old_word, wdata, be in; merged out.
module dm_be_merge
   import dm_pkg::*;
(
   input  logic [DM_DATA_W-1:0] old_word,
   input  logic [DM_DATA_W-1:0] wdata,
   input  logic [DM_BE_W-1:0]   be,
   output logic [DM_DATA_W-1:0] merged
);
   always_comb begin
      merged = old_word;
      for (int i = 0; i < DM_BE_W; i++) begin
         if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
      end
   end
endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, byte-enabled stores.
// Latency: request accepted at edge T -> resp_ack high in the cycle after edge T+LATENCY+1.
// Backpressure: single outstanding request; CPU stalls on req_valid & ~resp_ack.
// Ports: clk, reset (sync, active-high), bus (dm_responder_if.slave).
// Optional: define DM_WRITE_LOG_EN to print every completed in-range store.
module dm_responder
   import dm_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic           clk,
   input  logic           reset,
   dm_responder_if.slave  bus
);
   localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [30:0] DEPTH_W = 31'(DEPTH);
   localparam logic [3:0] LAT_W   = 4'(LATENCY);

   dm_state_t            state;
   logic [3:0]           cnt;
   logic                 we_q;
   logic [DM_ADDR_W-1:0] addr_q;
   logic [DM_DATA_W-1:0] wdata_q;
   logic [DM_BE_W-1:0]   be_q;
   logic [DM_ADDR_W-1:0] pc_q;
   logic [DM_DATA_W-1:0] acc_rdata_q;
   logic                 acc_err_q;
   logic [DM_DATA_W-1:0] mem [DEPTH];

   // With zero wait states the access happens on the acceptance edge, so it
   // must use the live bus fields rather than the (not yet loaded) latches.
   logic                 from_bus;
   logic                 do_access;
   logic                 acc_we;
   logic [DM_ADDR_W-1:0] acc_addr;
   logic [DM_DATA_W-1:0] acc_wdata;
   logic [DM_BE_W-1:0]   acc_be;
   logic [DM_ADDR_W-1:0] acc_pc;
   logic [29:0]          acc_idx;
   logic [AW-1:0]        widx;
   logic                 in_range;
   logic [DM_DATA_W-1:0] merged;
   logic                 unused_bits;

   assign from_bus  = (state == IDLE);
   assign do_access = (state == IDLE && bus.req_valid && LATENCY == 0) ||
                      (state == WAIT && cnt == 4'd1);
   assign acc_we    = from_bus ? bus.req_we    : we_q;
   assign acc_addr  = from_bus ? bus.req_addr  : addr_q;
   assign acc_wdata = from_bus ? bus.req_wdata : wdata_q;
   assign acc_be    = from_bus ? bus.req_be    : be_q;
   assign acc_pc    = from_bus ? bus.req_pc    : pc_q;
   assign acc_idx   = acc_addr[31:2];
   assign widx      = acc_idx[AW-1:0];
   assign in_range  = {1'b0, acc_idx} < DEPTH_W;
   assign bus.busy  = (state != IDLE);

   // Byte offset never selects a word; pc only feeds the optional log.
   assign unused_bits = ^{acc_addr[1:0], acc_pc};

   dm_be_merge u_merge (
      .old_word (mem[widx]),
      .wdata    (acc_wdata),
      .be       (acc_be),
      .merged   (merged)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         we_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         be_q           <= '0;
         pc_q           <= '0;
         acc_rdata_q    <= '0;
         acc_err_q      <= 1'b0;
         bus.resp_ack   <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         bus.resp_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  be_q    <= bus.req_be;
                  pc_q    <= bus.req_pc;
                  cnt     <= LAT_W;
                  state   <= (LATENCY == 0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP: begin
               // Ack is registered out of RESP, so it lands one cycle later
               // while the FSM is already back in IDLE.
               bus.resp_ack   <= 1'b1;
               bus.resp_rdata <= acc_rdata_q;
               bus.resp_err   <= acc_err_q;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (do_access) begin
            if (!in_range) begin
               acc_rdata_q <= '0;
               acc_err_q   <= 1'b1;
            end else if (acc_we) begin
               mem[widx]   <= merged;
               acc_rdata_q <= '0;
               acc_err_q   <= 1'b0;
`ifdef DM_WRITE_LOG_EN
               $display("@%08h: *%08h <= %08h", acc_pc, {acc_idx, 2'b00}, merged);
`endif
            end else begin
               acc_rdata_q <= mem[widx];
               acc_err_q   <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: two instances (LATENCY=2 and LATENCY=0),
// directed steps followed by random loads/stores checked against a word-array model.
// Ports: none.
module tb_dm_responder;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   dm_responder_if bus0 ();
   dm_responder_if bus1 ();

   dm_responder #(.DEPTH(1024), .LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   dm_responder #(.DEPTH(1024), .LATENCY(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   int tests = 0;
   int fails = 0;
   logic [31:0] mdl0 [1024];
   logic [31:0] mdl1 [1024];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] pc);
      if (sel) begin
         bus1.req_valid = v; bus1.req_we = we; bus1.req_addr = addr;
         bus1.req_wdata = wdata; bus1.req_be = be; bus1.req_pc = pc;
      end else begin
         bus0.req_valid = v; bus0.req_we = we; bus0.req_addr = addr;
         bus0.req_wdata = wdata; bus0.req_be = be; bus0.req_pc = pc;
      end
   endtask

   function automatic logic [33:0] outs(input bit sel);
      // {busy, ack, rdata} -- rdata in [31:0]
      return sel ? {bus1.busy, bus1.resp_ack, bus1.resp_rdata}
                 : {bus0.busy, bus0.resp_ack, bus0.resp_rdata};
   endfunction

   function automatic logic err_of(input bit sel);
      return sel ? bus1.resp_err : bus0.resp_err;
   endfunction

   task automatic clear_models();
      for (int i = 0; i < 1024; i++) begin
         mdl0[i] = 32'h0;
         mdl1[i] = 32'h0;
      end
   endtask

   // One full request: model prediction, drive, wait for ack (bounded), check.
   task automatic do_req(input bit sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] pc, input string tag);
      logic [29:0] w;
      logic [31:0] old, mask, exp_rd;
      logic        exp_err;
      logic [33:0] o;
      int          cyc;
      w = addr[31:2];
      exp_rd = 32'h0;
      exp_err = 1'b0;
      if (w >= 30'd1024) begin
         exp_err = 1'b1;
      end else begin
         old  = sel ? mdl1[w[9:0]] : mdl0[w[9:0]];
         mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
         if (we) begin
            if (sel) mdl1[w[9:0]] = (old & ~mask) | (wdata & mask);
            else     mdl0[w[9:0]] = (old & ~mask) | (wdata & mask);
         end else begin
            exp_rd = old;
         end
      end

      @(posedge clk); #1;
      drive(sel, 1'b1, we, addr, wdata, be, pc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         o = outs(sel);
      end while (!o[32] && cyc < 40);
      drive(sel, 1'b0, we, addr, wdata, be, pc);
      if (!o[32]) cyc = 999;
      chk({tag, "/latency"}, 32'(cyc), sel ? 32'd2 : 32'd4);
      chk({tag, "/rdata"}, o[31:0], exp_rd);
      chk({tag, "/err"}, {31'h0, err_of(sel)}, {31'h0, exp_err});
      @(posedge clk); #1;
      o = outs(sel);
      chk({tag, "/ack_pulse"}, {31'h0, o[32]}, 32'h0);
      chk({tag, "/idle"}, {31'h0, o[33]}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [33:0] o;
      logic        ack_seen;
      int          acks [$];
      logic [29:0] idxr;
      logic [31:0] rnd;
      bit          sel;

      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      clear_models();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state of both instances.
      o = outs(1'b0);
      chk("rst0/ack", {31'h0, o[32]}, 32'h0);
      chk("rst0/rdata", o[31:0], 32'h0);
      chk("rst0/err", {31'h0, err_of(1'b0)}, 32'h0);
      chk("rst0/busy", {31'h0, o[33]}, 32'h0);
      o = outs(1'b1);
      chk("rst1/ack", {31'h0, o[32]}, 32'h0);
      chk("rst1/busy", {31'h0, o[33]}, 32'h0);

      // Directed: basic load, full store, partial store, out-of-range, be=0.
      do_req(1'b0, 1'b0, 32'h0000_0010, 32'h0, 4'hF, 32'h1000, "ld_0x10");
      do_req(1'b0, 1'b1, 32'h0000_0000, 32'hDEADBEEF, 4'hF, 32'h3000, "st_0x0");
      do_req(1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'h0, 32'h3004, "ld_0x0");
      do_req(1'b0, 1'b1, 32'h0000_0004, 32'h11223344, 4'hF, 32'h3008, "st_0x4");
      do_req(1'b0, 1'b1, 32'h0000_0004, 32'hAABBCCDD, 4'b0010, 32'h300C, "st_0x4_be2");
      do_req(1'b0, 1'b0, 32'h0000_0004, 32'h0, 4'hF, 32'h3010, "ld_0x4");
      chk("merge_ref", mdl0[1], 32'h1122CC44);
      do_req(1'b0, 1'b1, 32'h0000_1000, 32'h55555555, 4'hF, 32'h3014, "st_oor");
      do_req(1'b0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'h3018, "ld_oor");
      do_req(1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'h301C, "ld_0x0_after_oor");
      do_req(1'b0, 1'b1, 32'h0000_0000, 32'h12345678, 4'h0, 32'h3020, "st_be0");
      do_req(1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'h3024, "ld_0x0_after_be0");

      // Reset pulsed while a store to 0x8 sits in WAIT.
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 32'h4000);
      @(posedge clk); #1;
      o = outs(1'b0);
      chk("rstmid/busy_before", {31'h0, o[33]}, 32'h1);
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 32'h8, 32'hCAFEF00D, 4'hF, 32'h4000);
      @(posedge clk); #1;
      reset = 1'b0;
      clear_models();
      o = outs(1'b0);
      chk("rstmid/busy_after", {31'h0, o[33]}, 32'h0);
      chk("rstmid/ack_after", {31'h0, o[32]}, 32'h0);
      ack_seen = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         o = outs(1'b0);
         if (o[32]) ack_seen = 1'b1;
      end
      chk("rstmid/no_ack", {31'h0, ack_seen}, 32'h0);
      do_req(1'b0, 1'b0, 32'h0000_0008, 32'h0, 4'hF, 32'h4004, "rstmid/ld_0x8");
      do_req(1'b0, 1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'h4008, "rstmid/ld_0x0");

      // LATENCY=0: back-to-back loads with req_valid held high.
      rnd = $urandom;
      do_req(1'b1, 1'b1, 32'h0000_000C, rnd, 4'hF, 32'h5000, "b2b/st");
      @(posedge clk); #1;
      drive(1'b1, 1'b1, 1'b0, 32'h0000_000C, 32'h0, 4'hF, 32'h5004);
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk); #1;
         o = outs(1'b1);
         if (o[32]) begin
            acks.push_back(c);
            chk("b2b/rdata", o[31:0], mdl1[3]);
         end
      end
      drive(1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h0, 4'hF, 32'h5004);
      chk("b2b/count", 32'(acks.size()), 32'd5);
      for (int i = 0; i < acks.size(); i++) chk("b2b/spacing", 32'(acks[i]), 32'(2 * (i + 1)));
      repeat (2) @(posedge clk);
      #1 o = outs(1'b1);
      chk("b2b/idle", {31'h0, o[33]}, 32'h0);

      // Random loads/stores on both instances.
      for (int n = 0; n < 60; n++) begin
         sel  = 1'($urandom_range(0, 1));
         idxr = ($urandom_range(0, 7) == 0) ? 30'(1024 + $urandom_range(0, 3))
                                            : 30'($urandom_range(0, 15));
         rnd  = $urandom;
         do_req(sel, 1'($urandom_range(0, 1)), {idxr, rnd[1:0]}, $urandom,
                4'($urandom_range(0, 15)), $urandom, "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
